// File: rtl/draw_sequencer_if.sv
// draw_sequencer_if: bundle of the draw sequencer's control/handshake signals.
//   master modport - the sequencer: samples go/collision/frame_tick/clear_done/
//                    req/done, drives clear_en/grant/cur_ch/state/pass_done/
//                    frame_cnt/game_over/timeout_err.
//   slave modport  - game logic and sprite controllers: the reverse view.
interface draw_sequencer_if #(
    parameter int NUM_CH = 2,
    parameter int FCW    = 8
) ();
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              go;
    logic              collision;
    logic              frame_tick;
    logic              clear_done;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] done;

    logic              clear_en;
    logic [NUM_CH-1:0] grant;
    logic [CW-1:0]     cur_ch;
    logic [1:0]        state;
    logic              pass_done;
    logic [FCW-1:0]    frame_cnt;
    logic              game_over;
    logic              timeout_err;

    modport master (
        input  go, collision, frame_tick, clear_done, req, done,
        output clear_en, grant, cur_ch, state, pass_done, frame_cnt,
               game_over, timeout_err
    );

    modport slave (
        output go, collision, frame_tick, clear_done, req, done,
        input  clear_en, grant, cur_ch, state, pass_done, frame_cnt,
               game_over, timeout_err
    );
endinterface

// File: rtl/draw_sequencer.sv
// draw_sequencer: frame-level controller sharing one VGA write path among
// NUM_CH sprite channels. Each frame: background clear, then one grant per
// requesting channel in index order, then pass_done and frame pacing.
// Ports:
//   clk, reset - system clock, synchronous active-high reset
//   bus        - draw_sequencer_if.master (go, collision, frame_tick,
//                clear_done, req, done in; clear_en, grant, cur_ch, state,
//                pass_done, frame_cnt, game_over, timeout_err out)
module draw_sequencer #(
    parameter int NUM_CH  = 2,
    parameter int TIMEOUT = 4096,
    parameter int FCW     = 8
) (
    input  logic             clk,
    input  logic             reset,
    draw_sequencer_if.master bus
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW = $clog2(NUM_CH + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WLIM = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAW  = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     ptr;
    logic [NUM_CH-1:0] grant;
    logic [CW-1:0]     cur_ch;
    logic              clear_en;
    logic              pass_done;
    logic [FCW-1:0]    frame_cnt;
    logic              game_over;
    logic              timeout_err;
    logic              tick_pend;
    logic              coll_flag;
    logic              waiting;     // pass finished, holding in DRAW for frame_tick
    logic [WW-1:0]     wdog;

    logic              found;
    logic [CW-1:0]     sel;
    logic              wd_fire;
    logic              done_hit;

    // Lowest requesting channel at or above ptr.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!found && i >= 32'(ptr) && bus.req[i]) begin
                found = 1'b1;
                sel   = CW'(i);
            end
        end
    end

    assign done_hit = bus.done[cur_ch];
    assign wd_fire  = (TIMEOUT > 0) && (wdog == WLIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            cur_ch      <= '0;
            clear_en    <= 1'b0;
            pass_done   <= 1'b0;
            frame_cnt   <= '0;
            game_over   <= 1'b0;
            timeout_err <= 1'b0;
            tick_pend   <= 1'b0;
            coll_flag   <= 1'b0;
            waiting     <= 1'b0;
            wdog        <= '0;
        end else begin
            pass_done <= 1'b0;

            // Ticks and collisions are latched while a frame is in progress;
            // the branches below override these where they are consumed.
            if (state_q == CLEAR || state_q == DRAW) begin
                if (bus.frame_tick) tick_pend <= 1'b1;
                if (bus.collision)  coll_flag <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (bus.go) begin
                        state_q  <= CLEAR;
                        clear_en <= 1'b1;
                    end
                end

                CLEAR: begin
                    if (bus.clear_done) begin
                        state_q  <= DRAW;
                        clear_en <= 1'b0;
                        ptr      <= '0;
                        waiting  <= 1'b0;
                    end
                end

                DRAW: begin
                    if (waiting) begin
                        if (bus.frame_tick) begin
                            state_q   <= CLEAR;
                            clear_en  <= 1'b1;
                            waiting   <= 1'b0;
                            tick_pend <= 1'b0;
                        end
                    end else if (grant != '0) begin
                        // A done coinciding with the watchdog limit is a normal done.
                        if (done_hit || wd_fire) begin
                            grant <= '0;
                            ptr   <= PW'(cur_ch) + PW'(1);
                            if (!done_hit) timeout_err <= 1'b1;
                        end else begin
                            wdog <= wdog + WW'(1);
                        end
                    end else if (found) begin
                        grant  <= NUM_CH'(1) << sel;
                        cur_ch <= sel;
                        wdog   <= '0;
                    end else begin
                        // Pass complete: collision outranks any pending tick.
                        pass_done <= 1'b1;
                        frame_cnt <= frame_cnt + FCW'(1);
                        tick_pend <= 1'b0;
                        if (coll_flag || bus.collision) begin
                            state_q   <= OVER;
                            game_over <= 1'b1;
                        end else if (tick_pend || bus.frame_tick) begin
                            state_q  <= CLEAR;
                            clear_en <= 1'b1;
                        end else begin
                            waiting <= 1'b1;
                        end
                    end
                end

                OVER: begin
                    if (bus.go) begin
                        state_q   <= CLEAR;
                        clear_en  <= 1'b1;
                        game_over <= 1'b0;
                        coll_flag <= 1'b0;
                        tick_pend <= 1'b0;
                        frame_cnt <= '0;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.clear_en    = clear_en;
    assign bus.grant       = grant;
    assign bus.cur_ch      = cur_ch;
    assign bus.state       = state_q;
    assign bus.pass_done   = pass_done;
    assign bus.frame_cnt   = frame_cnt;
    assign bus.game_over   = game_over;
    assign bus.timeout_err = timeout_err;
endmodule
